// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM state encoding and default unit-length width,
// used by the length timer, symbol decoder and output sequencer.
package morse_pkg;

    localparam int MORSE_LEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/morse_tick_gen.sv
// Unit-rate prescaler: counts 0..TICK_DIV-1 while enabled and emits a one-cycle tick
// on the wrap. With TICK_DIV=1 the counter is stuck at 0 and tick simply follows en.
module morse_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (restart)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/morse_len_timer.sv
// Morse element-length timer: loads a length in units and counts it down at the prescaled rate.
// Define MORSE_LEN_AUTORELOAD_EN to restart from the last loaded length on each terminal count.
module morse_len_timer
    import morse_pkg::*;
#(
    parameter int WIDTH    = MORSE_LEN_W,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    input  logic             pause,
    output logic [WIDTH-1:0] q_out,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic             done_n;
    logic             tick, tick_en, restart;

    // The prescaler only advances on cycles where the count itself would be allowed to move.
    assign tick_en = (state != ST_IDLE) && !pause && !clear && !load;
    assign restart = clear || load;

    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .en      (tick_en),
        .restart (restart),
        .tick    (tick)
    );

`ifdef MORSE_LEN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            reload_q <= '0;
        else if (load && !clear)
            reload_q <= data_in;
    end
`endif

    always_comb begin
        state_n = state;
        q_n     = q_out;
        done_n  = 1'b0;
        if (clear) begin
            state_n = ST_IDLE;
            q_n     = '0;
        end else if (load) begin
            q_n     = data_in;
            state_n = (data_in != '0) ? ST_RUN : ST_IDLE;
        end else if (state != ST_IDLE) begin
            if (pause) begin
                state_n = ST_HOLD;
            end else begin
                state_n = ST_RUN;
                if (tick && q_out != '0) begin
                    if (q_out == WIDTH'(1)) begin
                        done_n = 1'b1;
`ifdef MORSE_LEN_AUTORELOAD_EN
                        q_n     = reload_q;
`else
                        q_n     = '0;
                        state_n = ST_IDLE;
`endif
                    end else begin
                        q_n = q_out - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            q_out <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            q_out <= q_n;
            done  <= done_n;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_morse_len_timer.sv
// Bench for morse_len_timer: table vectors and corner sequences plus random stimulus checked
// against a unit-counting reference model, on a TICK_DIV=1 and a TICK_DIV=3 instance.
module tb_morse_len_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load, clear, pause;
    logic [3:0] data_in;
    logic [3:0] q1, q3;
    logic       b1, b3, d1, d3;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    morse_len_timer #(.WIDTH(4), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in), .clear(clear),
        .pause(pause), .q_out(q1), .busy(b1), .done(d1)
    );

    morse_len_timer #(.WIDTH(4), .TICK_DIV(3)) dut3 (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in), .clear(clear),
        .pause(pause), .q_out(q3), .busy(b3), .done(d3)
    );

    // Reference: remaining units, cycles spent in the current unit, and whether a length is live.
    typedef struct {
        int q;
        int elapsed;
        bit active;
        int reload;
        bit done;
    } model_t;

    model_t m1, m3;

    function automatic model_t mreset();
        model_t m;
        m.q = 0; m.elapsed = 0; m.active = 0; m.reload = 0; m.done = 0;
        return m;
    endfunction

    function automatic model_t mstep(model_t m, bit c, bit l, int d, bit p, int div);
        m.done = 0;
        if (c) begin
            m.q = 0; m.elapsed = 0; m.active = 0;
        end else if (l) begin
            m.q = d; m.elapsed = 0; m.active = (d != 0); m.reload = d;
        end else if (m.active && !p) begin
            m.elapsed++;
            if (m.elapsed == div) begin
                m.elapsed = 0;
                m.q--;
                if (m.q == 0) begin
                    m.done = 1;
`ifdef MORSE_LEN_AUTORELOAD_EN
                    m.q = m.reload;
`else
                    m.active = 0;
`endif
                end
            end
        end
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_models();
        chk("m1_q", int'(q1), m1.q);
        chk("m1_busy", int'(b1), int'(m1.active));
        chk("m1_done", int'(d1), int'(m1.done));
        chk("m3_q", int'(q3), m3.q);
        chk("m3_busy", int'(b3), int'(m3.active));
        chk("m3_done", int'(d3), int'(m3.done));
    endtask

    task automatic cyc(input bit c, input bit l, input int d, input bit p);
        clear = c; load = l; data_in = 4'(d); pause = p;
        @(posedge clk);
        #1;
        m1 = mstep(m1, c, l, d, p, 1);
        m3 = mstep(m3, c, l, d, p, 3);
        chk_models();
    endtask

    // Asynchronous reset pulse between edges; outputs must drop before the next edge.
    task automatic async_reset();
        #1 reset = 1'b1;
        #1;
        chk("arst_q1", int'(q1), 0);
        chk("arst_b1", int'(b1), 0);
        chk("arst_d1", int'(d1), 0);
        chk("arst_q3", int'(q3), 0);
        chk("arst_b3", int'(b3), 0);
        m1 = mreset();
        m3 = mreset();
        #1 reset = 1'b0;
    endtask

    typedef struct {
        bit c, l;
        int d;
        bit p;
        int q;
        bit b, dn;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset = 1'b1; load = 0; clear = 0; pause = 0; data_in = '0;
        m1 = mreset(); m3 = mreset();
        #12;
        chk("rst_q1", int'(q1), 0);
        chk("rst_b1", int'(b1), 0);
        chk("rst_d1", int'(d1), 0);
        chk("rst_q3", int'(q3), 0);
        reset = 1'b0;

`ifndef MORSE_LEN_AUTORELOAD_EN
        // TICK_DIV=1 instance: {clear, load, data, pause, q, busy, done}
        tbl.push_back('{0,1,5,0, 5,1,0});
        tbl.push_back('{0,0,0,0, 4,1,0});
        tbl.push_back('{0,0,0,0, 3,1,0});
        tbl.push_back('{0,0,0,0, 2,1,0});
        tbl.push_back('{0,0,0,0, 1,1,0});
        tbl.push_back('{0,0,0,0, 0,0,1});
        tbl.push_back('{0,0,0,0, 0,0,0});
        tbl.push_back('{0,0,0,1, 0,0,0});  // pause in idle ignored
        tbl.push_back('{0,1,9,0, 9,1,0});
        for (int k = 8; k >= 3; k--) tbl.push_back('{0,0,0,0, k,1,0});
        tbl.push_back('{1,1,9,0, 0,0,0});  // clear beats load
        tbl.push_back('{0,0,0,0, 0,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0});
        tbl.push_back('{0,1,15,0, 15,1,0});
        for (int k = 14; k >= 10; k--) tbl.push_back('{0,0,0,0, k,1,0});
        tbl.push_back('{0,1,2,0, 2,1,0});  // reload mid-count
        tbl.push_back('{0,0,0,0, 1,1,0});
        tbl.push_back('{0,0,0,0, 0,0,1});
        tbl.push_back('{0,0,0,0, 0,0,0});
        tbl.push_back('{0,1,0,0, 0,0,0});  // load 0 stays idle
        tbl.push_back('{0,0,0,0, 0,0,0});
        tbl.push_back('{0,1,7,0, 7,1,0});
        tbl.push_back('{0,1,0,0, 0,0,0});  // load 0 aborts without done
        tbl.push_back('{0,0,0,0, 0,0,0});
        tbl.push_back('{0,1,3,1, 3,1,0});  // load while paused
        tbl.push_back('{0,0,0,1, 3,1,0});
        tbl.push_back('{0,0,0,0, 2,1,0});
        tbl.push_back('{0,0,0,0, 1,1,0});
        tbl.push_back('{0,0,0,0, 0,0,1});
        tbl.push_back('{0,1,1,0, 1,1,0});
        tbl.push_back('{0,0,0,0, 0,0,1});
        tbl.push_back('{0,0,0,0, 0,0,0});

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].c, tbl[i].l, tbl[i].d, tbl[i].p);
            chk($sformatf("tbl%0d_q", i), int'(q1), tbl[i].q);
            chk($sformatf("tbl%0d_busy", i), int'(b1), int'(tbl[i].b));
            chk($sformatf("tbl%0d_done", i), int'(d1), int'(tbl[i].dn));
        end

        // TICK_DIV=3: load 2 -> 2 for 3 cycles, 1 for 3 cycles, then 0 with done.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 2, 0);
        chk("div3_q0", int'(q3), 2);
        for (int k = 1; k <= 6; k++) begin
            int eq;
            eq = (k < 3) ? 2 : (k < 6) ? 1 : 0;
            cyc(0, 0, 0, 0);
            chk($sformatf("div3_q%0d", k), int'(q3), eq);
            chk($sformatf("div3_done%0d", k), int'(d3), (k == 6) ? 1 : 0);
            chk($sformatf("div3_busy%0d", k), int'(b3), (k == 6) ? 0 : 1);
        end
        cyc(0, 0, 0, 0);
        chk("div3_done_once", int'(d3), 0);

        // TICK_DIV=1: load 6, pause 4 cycles at q=4; done lands 4 cycles late (edge 10).
        cyc(1, 0, 0, 0);
        cyc(0, 1, 6, 0);
        for (int k = 1; k <= 11; k++) begin
            bit p;
            int eq;
            p = (k >= 3 && k <= 6);
            eq = (k <= 2) ? 6 - k : (k <= 6) ? 4 : (k <= 10) ? 10 - k : 0;
            cyc(0, 0, 0, p);
            chk($sformatf("pause_q%0d", k), int'(q1), eq);
            chk($sformatf("pause_done%0d", k), int'(d1), (k == 10) ? 1 : 0);
        end

        // Async reset mid-count; no done afterwards.
        cyc(0, 1, 9, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        async_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0);
            chk("post_arst_done", int'(d1), 0);
        end
`else
        // Auto-reload: load 3 -> 3,2,1,3,2,1,... with done on each reload.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 3, 0);
        chk("ar_q0", int'(q1), 3);
        for (int k = 1; k <= 9; k++) begin
            int eq;
            eq = 3 - (k % 3);
            cyc(0, 0, 0, 0);
            chk($sformatf("ar_q%0d", k), int'(q1), eq);
            chk($sformatf("ar_done%0d", k), int'(d1), (k % 3 == 0) ? 1 : 0);
            chk($sformatf("ar_busy%0d", k), int'(b1), 1);
        end
        async_reset();
`endif

        // Random stimulus against the reference model.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit c, l, p;
            int d;
            c = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 3) == 0);
            d = $urandom_range(0, 15);
            cyc(c, l, d, p);
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
